// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for an external 1-bit ALU slice (AND/OR/NOR/ADD/SUB/SLT), LSB first.
// Optional macro ALU_SERIAL_FLAGS_EN enables the overflow and zero flags.
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       func,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_sm,
    output logic             slice_sa,
    output logic             slice_sb,
    output logic             slice_cin,
    output logic [1:0]       slice_op,
    input  logic             slice_result,
    input  logic             slice_cout
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] F_AND = 3'b000;
    localparam logic [2:0] F_OR  = 3'b001;
    localparam logic [2:0] F_ADD = 3'b010;
    localparam logic [2:0] F_SUB = 3'b011;
    localparam logic [2:0] F_SLT = 3'b100;
    localparam logic [2:0] F_NOR = 3'b101;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cin_msb_q, cin_msb_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [2:0]       func_q, func_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;

    logic last_bit_s;
    logic addsub_s;
    logic less_s;

    assign last_bit_s = (cnt_q == CW'(WIDTH - 1));
    assign addsub_s   = (func_q == F_ADD) || (func_q == F_SUB);
    // Signed compare: sum MSB corrected by the MSB overflow term.
    assign less_s     = res_q[WIDTH-1] ^ (cin_msb_q ^ carry_q);

    // Slice operand and control decode from the current state and latched function.
    always_comb begin
        slice_a   = 1'b0;
        slice_b   = 1'b0;
        slice_sm  = 1'b0;
        slice_sa  = 1'b0;
        slice_sb  = 1'b0;
        slice_cin = 1'b0;
        slice_op  = 2'b00;
        case (state_q)
            S_RUN: begin
                slice_a   = a_sh_q[0];
                slice_b   = b_sh_q[0];
                slice_cin = carry_q;
                case (func_q)
                    F_AND: slice_op = 2'b00;
                    F_OR:  slice_op = 2'b01;
                    F_NOR: begin
                        slice_op = 2'b00;
                        slice_sa = 1'b1;
                        slice_sb = 1'b1;
                    end
                    F_ADD: slice_op = 2'b10;
                    F_SUB, F_SLT: begin
                        slice_op = 2'b10;
                        slice_sb = 1'b1;
                    end
                    default: slice_op = 2'b11;
                endcase
            end
            S_FIX: begin
                slice_op = 2'b11;
                slice_sm = less_s;
            end
            default: slice_op = 2'b00;
        endcase
    end

    // Sequencer next-state, shift registers and carry-out flag.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        cin_msb_d = cin_msb_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        res_d     = res_q;
        func_d    = func_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cout_d    = cout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    func_d  = func;
                    cnt_d   = {CW{1'b0}};
                    carry_d = (func == F_SUB) || (func == F_SLT);
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                res_d   = {slice_result, res_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = slice_cout;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit_s) begin
                    cin_msb_d = carry_q;
                    if (func_q == F_SLT) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        cout_d  = addsub_s ? slice_cout : 1'b0;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FIX: begin
                res_d   = {{(WIDTH-1){1'b0}}, slice_result};
                state_d = S_DONE;
                done_d  = 1'b1;
                cout_d  = 1'b0;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            carry_q   <= 1'b0;
            cin_msb_q <= 1'b0;
            a_sh_q    <= {WIDTH{1'b0}};
            b_sh_q    <= {WIDTH{1'b0}};
            res_q     <= {WIDTH{1'b0}};
            func_q    <= 3'b000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            cin_msb_q <= cin_msb_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            res_q     <= res_d;
            func_q    <= func_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cout_q    <= cout_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = res_q;
    assign carry_out = cout_q;

`ifdef ALU_SERIAL_FLAGS_EN
    logic ovf_q, ovf_d;
    logic zero_q, zero_d;

    // Flags are captured on the edge that enters DONE, from the final result value.
    always_comb begin
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if ((state_q == S_RUN) && last_bit_s && (func_q != F_SLT)) begin
            ovf_d  = addsub_s ? (carry_q ^ slice_cout) : 1'b0;
            zero_d = (res_d == {WIDTH{1'b0}});
        end else if (state_q == S_FIX) begin
            ovf_d  = cin_msb_q ^ carry_q;
            zero_d = (res_d == {WIDTH{1'b0}});
        end else begin
            ovf_d  = ovf_q;
            zero_d = zero_q;
        end
    end

    // Flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign overflow = ovf_q;
    assign zero     = zero_q;
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl (WIDTH=8) with a behavioural 1-bit ALU slice.
module tb_alu_serial_ctrl;
    localparam int W = 8;
`ifdef ALU_SERIAL_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   func = 3'b000;
    logic [W-1:0] a_in = 8'h00;
    logic [W-1:0] b_in = 8'h00;
    logic         busy, done, carry_out, overflow, zero;
    logic [W-1:0] result;
    logic         slice_a, slice_b, slice_sm, slice_sa, slice_sb, slice_cin;
    logic [1:0]   slice_op;
    logic         slice_result, slice_cout;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func(func),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero),
        .slice_a(slice_a), .slice_b(slice_b), .slice_sm(slice_sm),
        .slice_sa(slice_sa), .slice_sb(slice_sb), .slice_cin(slice_cin),
        .slice_op(slice_op), .slice_result(slice_result), .slice_cout(slice_cout)
    );

    always #5 clk = ~clk;

    // External ALU slice: optional operand inversion, then AND/OR/SUM/pass-sm.
    logic ai, bi;
    always_comb begin
        ai = slice_a ^ slice_sa;
        bi = slice_b ^ slice_sb;
        slice_cout = (ai & bi) | (slice_cin & (ai ^ bi));
        case (slice_op)
            2'b00:   slice_result = ai & bi;
            2'b01:   slice_result = ai | bi;
            2'b10:   slice_result = ai ^ bi ^ slice_cin;
            default: slice_result = slice_sm;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         o;
        logic         z;
        int           issue;
        int           lat;
    } exp_t;
    exp_t sb_q[$];

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] f, input logic [W-1:0] r,
                                input logic c, input logic o, input logic z, input int iss);
        exp_t e;
        e.res   = r;
        e.c     = c;
        e.o     = FLAGS ? o : 1'b0;
        e.z     = FLAGS ? z : 1'b0;
        e.issue = iss;
        e.lat   = (f == 3'b100) ? W + 2 : W + 1;
        return e;
    endfunction

    // Monitor: every done pulse is matched against the oldest expected response.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("carry_out", 32'(carry_out), 32'(e.c));
                chk("overflow", 32'(overflow), 32'(e.o));
                chk("zero", 32'(zero), 32'(e.z));
                chk("latency", 32'(cyc - e.issue), 32'(e.lat));
                chk("busy_in_done", 32'(busy), 32'd1);
                chk("slice_idle_in_done",
                    32'({slice_a, slice_b, slice_sm, slice_sa, slice_sb, slice_cin, slice_op}), 32'd0);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || done) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL wait_idle: got busy=%0b expected 0 within 50 cycles", busy);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r, input logic c, input logic o, input logic z);
        @(negedge clk);
        wait_idle();
        start = 1'b1;
        func  = f;
        a_in  = a;
        b_in  = b;
        sb_q.push_back(mk(f, r, c, o, z, cyc));
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({carry_out, overflow, zero}), 32'd0);
        chk("rst_slice", 32'({slice_a, slice_b, slice_sm, slice_sa, slice_sb, slice_cin, slice_op}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of an ADD, while the third bit is on the slice.
        @(negedge clk);
        start = 1'b1; func = 3'b010; a_in = 8'h7F; b_in = 8'h01;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy_before_rst", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_slice", 32'({slice_a, slice_b, slice_cin, slice_op}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_done_busy", 32'(busy), 32'd0);

        issue(3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        issue(3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        issue(3'b010, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);
        issue(3'b011, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0);
        issue(3'b011, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
        issue(3'b011, 8'h34, 8'h34, 8'h00, 1'b1, 1'b0, 1'b1);
        issue(3'b100, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
        issue(3'b100, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1);
        issue(3'b100, 8'h80, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0);
        issue(3'b100, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1);
        issue(3'b000, 8'hC3, 8'h5A, 8'h42, 1'b0, 1'b0, 1'b0);
        issue(3'b001, 8'hC3, 8'h5A, 8'hDB, 1'b0, 1'b0, 1'b0);
        issue(3'b101, 8'hC3, 8'h5A, 8'h24, 1'b0, 1'b0, 1'b0);
        issue(3'b111, 8'hC3, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1);
        issue(3'b110, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);

        // start held high: the second op (OR) is taken only in the cycle after done.
        @(negedge clk);
        wait_idle();
        start = 1'b1; func = 3'b000; a_in = 8'hC3; b_in = 8'h5A;
        sb_q.push_back(mk(3'b000, 8'h42, 1'b0, 1'b0, 1'b0, cyc));
        sb_q.push_back(mk(3'b001, 8'hDB, 1'b0, 1'b0, 1'b0, cyc + W + 2));
        @(negedge clk);
        func = 3'b001;
        repeat (W + 2) @(negedge clk);
        start = 1'b0;

        begin
            int n;
            n = 0;
            while (sb_q.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("pending_ops_drained", 32'(sb_q.size()), 32'd0);
        end
        repeat (2) @(negedge clk);
        chk("final_idle", 32'(busy), 32'd0);
        chk("result_held", 32'(result), 32'hDB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Sequencer that drives one external 1-bit ALU slice bit-serially, LSB first, to perform WIDTH-bit operations: AND, OR, NOR, ADD, SUB, SLT.
- Holds operand/result shift registers and the carry flip-flop, and runs a start/done handshake toward the issuing unit.
- Sits between the pipeline execute-stage control and a single shared ALU slice instance.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when busy=0
func  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 NOR, 110/111 illegal
a_in  input  WIDTH  operand A, sampled with accepted start
b_in  input  WIDTH  operand B, sampled with accepted start
busy  output  1  high from cycle after accept until done cycle inclusive
done  output  1  one-cycle pulse, result/flags valid
result  output  WIDTH  result, held until next accept
carry_out  output  1  carry out of MSB (ADD/SUB), else 0
overflow  output  1  signed overflow (ADD/SUB/SLT), see Optional Feature
zero  output  1  result==0, see Optional Feature
slice_a, slice_b  output  1  operand bits to slice
slice_sm, slice_sa, slice_sb, slice_cin  output  1  slice controls
slice_op  output  2  slice op: 00 AND, 01 OR, 10 SUM, 11 pass sm
slice_result, slice_cout  input  1  slice outputs (combinational)

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0, zero=0; counter, carry reg, shift regs = 0; all slice_* outputs 0.
- States: IDLE, RUN, FIX, DONE.
- IDLE: start=1 latches a_in, b_in, func; counter=0; carry reg=1 for SUB/SLT, else 0; next RUN. start=0 stays IDLE. start in any other state is ignored, not queued.
- RUN, one bit per cycle:
  - slice_a=a_sh[0], slice_b=b_sh[0], slice_cin=carry reg, slice_sm=0.
  - Mapping: AND op=00 sa=0 sb=0; OR op=01; NOR op=00 sa=1 sb=1; ADD op=10; SUB/SLT op=10 sb=1; illegal op=11 sm=0.
  - Each edge: result shift reg shifts right with slice_result entering at MSB; a_sh/b_sh shift right; carry reg<=slice_cout; counter++.
  - On counter==WIDTH-1: record cin_msb=carry reg (before update); next FIX if SLT, else DONE.
- FIX (SLT only, 1 cycle):
  - less = sum_msb XOR (cin_msb XOR final carry), i.e. the signed compare.
  - Drive slice_op=11, slice_sm=less; result <= {WIDTH-1 zeros, slice_result}.
  - Next DONE.
- DONE (1 cycle): done=1, busy=1. Flags are registered on entry:
  - carry_out = final carry for ADD/SUB, else 0.
  - overflow = cin_msb XOR final carry for ADD/SUB/SLT, else 0.
  - zero = (result==0).
  - Next IDLE; start in DONE is ignored.
- Latency: accept edge to done high = WIDTH+1 cycles; SLT = WIDTH+2. Back-to-back issue is possible on the cycle after done.
- Illegal func: completes with normal latency, result=0, carry_out=0, overflow=0, zero=1.
- slice_* outputs are 0 in IDLE and DONE.
- Reset mid-operation aborts immediately; no done pulse.
- result/flags stay stable from done until the next accept.

Optional Feature:
- Macro ALU_SERIAL_FLAGS_EN.
- Defined: overflow and zero computed as above.
- Undefined: overflow and zero tied to 0 and their logic removed; ports remain present; carry_out unaffected.

Test Plan (WIDTH=8):
- Reset mid-RUN of ADD: rst_n low at 3rd bit -> outputs 0 immediately, state IDLE, no done pulse; new start afterwards completes normally.
- ADD 0x7F+0x01 -> done 9 cycles after accept, result 0x80, carry_out=0, overflow=1, zero=0; ADD 0xFF+0x01 -> result 0x00, carry_out=1, overflow=0, zero=1.
- SUB 0x05-0x07 -> result 0xFE, carry_out=0, overflow=0; SUB 0x80-0x01 -> result 0x7F, overflow=1.
- SLT 0x80 vs 0x01 -> result 0x01, done at cycle 10; SLT 0x01 vs 0x80 -> 0x00; SLT 0x80 vs 0x7F -> 0x01 (overflow corrected).
- AND 0xC3&0x5A -> 0x42; OR -> 0xDB; NOR -> 0x24; func=111 -> result 0x00, zero=1.
- start held high through busy and DONE -> second op accepted only on the cycle after done; build without ALU_SERIAL_FLAGS_EN -> overflow/zero always 0.
